// File: rtl/immgen_pipe.sv
// rtl/immgen_pipe.sv - pipelined RV32I/RV64I immediate generator with 2-entry skid buffer
//
// Purpose:
//   Decodes the immediate of an instruction word (I/S/B/U/J formats plus the
//   CSR zimm field) and extends it to XLEN bits.
//   Each result is pushed with its sideband tag into a 2-entry FIFO.
//   The FIFO head drives the out_* ports, so fetch and decode can stall
//   independently without losing words.
//
// Parameters:
//   XLEN     - 32 or 64; width of out_imm.
//   AUTO_SEL - 1: format derived from inst[6:0], in_immsrc ignored;
//              0: format taken from in_immsrc.
//   TAG_W    - width of the sideband tag.
//
// Ports:
//   clk, rst_n                  - clock, synchronous active-low reset
//   in_valid/in_ready           - input handshake (in_ready is registered)
//   in_inst, in_immsrc, in_tag  - instruction word, format select, sideband
//   out_valid/out_ready         - output handshake
//   out_imm, out_tag            - extended immediate and its tag
//   out_illegal                 - select (or opcode) mapped to no format
//
// Optional build macro IMMGEN_PIPE_PERF_EN:
//   adds perf_accepted and perf_illegal, which are 32-bit wrapping counters
//   of input transfers and of illegal input transfers.

module immgen_pipe #(
  parameter int XLEN     = 32,
  parameter int AUTO_SEL = 0,
  parameter int TAG_W    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  input  logic [2:0]       in_immsrc,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_illegal
`ifdef IMMGEN_PIPE_PERF_EN
  ,
  output logic [31:0]      perf_accepted,
  output logic [31:0]      perf_illegal
`endif
);

  typedef enum logic [2:0] {
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J,
    FMT_Z,
    FMT_ZERO,
    FMT_ILL
  } fmt_e;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_IMM32  = 7'b0011011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_REG32  = 7'b0111011;

  fmt_e             w_fmt;
  logic [XLEN-1:0]  w_imm;
  logic             w_ill;
  logic             w_push;
  logic             w_pop;
  logic [1:0]       w_count_next;
  logic             w_unused_ok;

  logic [XLEN-1:0]  r_imm [2];
  logic [TAG_W-1:0] r_tag [2];
  logic             r_ill [2];
  logic             r_wr_ptr;
  logic             r_rd_ptr;
  logic [1:0]       r_count;
  logic             r_in_ready;

  // Depending on AUTO_SEL, either the opcode bits or in_immsrc go unread.
  assign w_unused_ok = ^{in_inst[6:0], in_inst[14:12], in_immsrc};

  // Format selection
  always_comb begin
    w_fmt = FMT_ILL;
    if (AUTO_SEL != 0) begin
      case (in_inst[6:0])
        OP_IMM, OP_LOAD, OP_JALR, OP_IMM32: w_fmt = FMT_I;
        OP_STORE:                           w_fmt = FMT_S;
        OP_BRANCH:                          w_fmt = FMT_B;
        OP_LUI, OP_AUIPC:                   w_fmt = FMT_U;
        OP_JAL:                             w_fmt = FMT_J;
        // funct3[2] separates the immediate CSR forms from csrrw/s/c and ecall.
        OP_SYSTEM:                          w_fmt = in_inst[14] ? FMT_Z : FMT_I;
        // R-type carries no immediate but is still a legal instruction.
        OP_REG, OP_REG32:                   w_fmt = FMT_ZERO;
        default:                            w_fmt = FMT_ILL;
      endcase
    end else begin
      case (in_immsrc)
        3'b000:  w_fmt = FMT_I;
        3'b001:  w_fmt = FMT_S;
        3'b101:  w_fmt = FMT_B;
        3'b010:  w_fmt = FMT_U;
        3'b011:  w_fmt = FMT_J;
        3'b100:  w_fmt = FMT_Z;
        default: w_fmt = FMT_ILL;
      endcase
    end
  end

  // Extension
  // A size cast of a $signed operand sign-extends.
  always_comb begin
    w_imm = '0;
    w_ill = 1'b0;
    case (w_fmt)
      FMT_I: w_imm = XLEN'($signed(in_inst[31:20]));
      FMT_S: w_imm = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
      FMT_B: w_imm = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25],
                                    in_inst[11:8], 1'b0}));
      FMT_U: w_imm = XLEN'($signed({in_inst[31:12], 12'b0}));
      FMT_J: w_imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20],
                                    in_inst[30:21], 1'b0}));
      FMT_Z: w_imm = XLEN'(in_inst[19:15]);
      FMT_ZERO: w_imm = '0;
      default: begin
        w_imm = '0;
        w_ill = 1'b1;
      end
    endcase
  end

  // Handshake and occupancy
  assign w_push = in_valid && r_in_ready;
  assign w_pop  = (r_count != 2'd0) && out_ready;

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + 2'd1;
      2'b01:   w_count_next = r_count - 2'd1;
      default: w_count_next = r_count;
    endcase
  end

  // in_ready is registered from the next occupancy.
  // This keeps out_ready off any combinational path to in_ready.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_count    <= 2'd0;
      r_wr_ptr   <= 1'b0;
      r_rd_ptr   <= 1'b0;
      r_in_ready <= 1'b1;
      for (int i = 0; i < 2; i++) begin
        r_imm[i] <= '0;
        r_tag[i] <= '0;
        r_ill[i] <= 1'b0;
      end
    end else begin
      if (w_push) begin
        r_imm[r_wr_ptr] <= w_imm;
        r_tag[r_wr_ptr] <= in_tag;
        r_ill[r_wr_ptr] <= w_ill;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count    <= w_count_next;
      r_in_ready <= (w_count_next < 2'd2);
    end
  end

  assign in_ready    = r_in_ready;
  assign out_valid   = (r_count != 2'd0);
  assign out_imm     = r_imm[r_rd_ptr];
  assign out_tag     = r_tag[r_rd_ptr];
  assign out_illegal = r_ill[r_rd_ptr];

`ifdef IMMGEN_PIPE_PERF_EN
  logic [31:0] r_perf_accepted;
  logic [31:0] r_perf_illegal;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_perf_accepted <= '0;
      r_perf_illegal  <= '0;
    end else if (w_push) begin
      r_perf_accepted <= r_perf_accepted + 32'd1;
      if (w_ill) begin
        r_perf_illegal <= r_perf_illegal + 32'd1;
      end
    end
  end

  assign perf_accepted = r_perf_accepted;
  assign perf_illegal  = r_perf_illegal;
`endif

endmodule

// File: tb/tb_immgen_pipe.sv
// tb/tb_immgen_pipe.sv - scoreboard bench for immgen_pipe (XLEN=64 select mode, XLEN=32 auto mode)
`timescale 1ns/1ps
module tb_immgen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [4:0]  tag;
    logic        ill;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_illegal;
  logic [31:0] a_in_inst;
  logic [2:0]  a_in_immsrc;
  logic [4:0]  a_in_tag, a_out_tag;
  logic [63:0] a_out_imm;

  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_illegal;
  logic [31:0] b_in_inst;
  logic [2:0]  b_in_immsrc;
  logic [4:0]  b_in_tag, b_out_tag;
  logic [31:0] b_out_imm;

`ifdef IMMGEN_PIPE_PERF_EN
  logic [31:0] a_perf_acc, a_perf_ill, b_perf_acc, b_perf_ill;
`endif

  immgen_pipe #(.XLEN(64), .AUTO_SEL(0), .TAG_W(5)) u_dut_a (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (a_in_valid),
    .in_ready   (a_in_ready),
    .in_inst    (a_in_inst),
    .in_immsrc  (a_in_immsrc),
    .in_tag     (a_in_tag),
    .out_valid  (a_out_valid),
    .out_ready  (a_out_ready),
    .out_imm    (a_out_imm),
    .out_tag    (a_out_tag),
    .out_illegal(a_out_illegal)
`ifdef IMMGEN_PIPE_PERF_EN
    ,
    .perf_accepted(a_perf_acc),
    .perf_illegal (a_perf_ill)
`endif
  );

  immgen_pipe #(.XLEN(32), .AUTO_SEL(1), .TAG_W(5)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (b_in_valid),
    .in_ready   (b_in_ready),
    .in_inst    (b_in_inst),
    .in_immsrc  (b_in_immsrc),
    .in_tag     (b_in_tag),
    .out_valid  (b_out_valid),
    .out_ready  (b_out_ready),
    .out_imm    (b_out_imm),
    .out_tag    (b_out_tag),
    .out_illegal(b_out_illegal)
`ifdef IMMGEN_PIPE_PERF_EN
    ,
    .perf_accepted(b_perf_acc),
    .perf_illegal (b_perf_ill)
`endif
  );

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t a_q[$];
  exp_t b_q[$];
  int   a_outs     = 0;
  int   push_waits = 0;
  int   a_acc      = 0;
  int   a_ill_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Output monitors: compare the head against the scoreboard on every output transfer.
  always @(negedge clk) begin : mon_a
    exp_t e;
    if (rst_n && a_out_valid && a_out_ready) begin
      a_outs++;
      if (a_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL a_unexpected_output: got tag %0d expected none", a_out_tag);
      end else begin
        e = a_q.pop_front();
        chk("a_imm", a_out_imm, e.imm);
        chk("a_tag", {59'b0, a_out_tag}, {59'b0, e.tag});
        chk("a_illegal", {63'b0, a_out_illegal}, {63'b0, e.ill});
      end
    end
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (rst_n && b_out_valid && b_out_ready) begin
      if (b_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL b_unexpected_output: got tag %0d expected none", b_out_tag);
      end else begin
        e = b_q.pop_front();
        chk("b_imm", {32'b0, b_out_imm}, e.imm);
        chk("b_tag", {59'b0, b_out_tag}, {59'b0, e.tag});
        chk("b_illegal", {63'b0, b_out_illegal}, {63'b0, e.ill});
      end
    end
  end

  // Entered at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input bit sel_b, input logic [31:0] inst, input logic [2:0] src,
                      input logic [4:0] tag, input logic [63:0] imm, input logic ill);
    exp_t e;
    int   k;
    logic rdy;
    if (sel_b) begin
      b_in_valid = 1'b1; b_in_inst = inst; b_in_immsrc = src; b_in_tag = tag;
    end else begin
      a_in_valid = 1'b1; a_in_inst = inst; a_in_immsrc = src; a_in_tag = tag;
    end
    k = 0;
    @(negedge clk);
    rdy = sel_b ? b_in_ready : a_in_ready;
    while (!rdy && k < 50) begin
      k++;
      @(negedge clk);
      rdy = sel_b ? b_in_ready : a_in_ready;
    end
    push_waits += k;
    if (!rdy) begin
      n_checks++;
      n_fail++;
      $display("FAIL push_timeout: tag %0d got in_ready 0 expected 1 within 50 cycles", tag);
    end else begin
      e.imm = imm; e.tag = tag; e.ill = ill;
      if (sel_b) b_q.push_back(e);
      else begin
        a_q.push_back(e);
        a_acc++;
        if (ill) a_ill_cnt++;
      end
    end
    @(posedge clk);
    #1;
    a_in_valid = 1'b0;
    b_in_valid = 1'b0;
  endtask

  logic [31:0] a_inst [10] = '{32'hFFF00093, 32'h00A12423, 32'hFE000EE3, 32'h800002B7,
                               32'h0080006F, 32'h0002D073, 32'h0002D073, 32'hFFF00093,
                               32'h800002B7, 32'h7FF00093};
  logic [2:0]  a_src  [10] = '{3'b000, 3'b001, 3'b101, 3'b010, 3'b011, 3'b100, 3'b111,
                               3'b110, 3'b000, 3'b001};
  logic [63:0] a_exp  [10] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h8, 64'hFFFF_FFFF_FFFF_FFFC,
                               64'hFFFF_FFFF_8000_0000, 64'h8, 64'h5, 64'h0, 64'h0,
                               64'hFFFF_FFFF_FFFF_F800, 64'h7E1};
  logic        a_eill [10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0};

  logic [31:0] b_inst [9] = '{32'h00B50533, 32'h0002D073, 32'h34011073, 32'h00000000,
                              32'h800002B7, 32'hFE000EE3, 32'h00A12423, 32'h0080006F,
                              32'hFFE5051B};
  logic [63:0] b_exp  [9] = '{64'h0, 64'h5, 64'h340, 64'h0, 64'h8000_0000, 64'hFFFF_FFFC,
                              64'h8, 64'h8, 64'hFFFF_FFFE};
  logic        b_eill [9] = '{0, 0, 0, 1, 0, 0, 0, 0, 0};

  initial begin
    int k;
    int outs0;
    int waits0;
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_inst = '0; a_in_immsrc = '0; a_in_tag = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_in_inst = '0; b_in_immsrc = '0; b_in_tag = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", {63'b0, a_out_valid}, 64'd0);
    chk("rst_in_ready", {63'b0, a_in_ready}, 64'd1);
    chk("rst_out_imm", a_out_imm, 64'd0);
    chk("rst_out_tag", {59'b0, a_out_tag}, 64'd0);
    chk("rst_out_illegal", {63'b0, a_out_illegal}, 64'd0);
`ifdef IMMGEN_PIPE_PERF_EN
    chk("rst_perf_acc", {32'b0, a_perf_acc}, 64'd0);
`endif
    @(posedge clk);
    #1;

    // XLEN=32 auto-select: addi x1,x0,-1 with one-cycle latency
    push(1'b1, 32'hFFF00093, 3'b111, 5'd1, 64'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    chk("b_latency_out_valid", {63'b0, b_out_valid}, 64'd1);
    @(posedge clk);
    #1;
    for (int i = 0; i < 9; i++) begin
      push(1'b1, b_inst[i], 3'b111, 5'(i + 2), b_exp[i], b_eill[i]);
    end

    // XLEN=64 explicit select
    for (int i = 0; i < 10; i++) begin
      push(1'b0, a_inst[i], a_src[i], 5'(i + 1), a_exp[i], a_eill[i]);
    end
    repeat (3) @(posedge clk);
    #1;
`ifdef IMMGEN_PIPE_PERF_EN
    chk("perf_accepted", {32'b0, a_perf_acc}, 64'(a_acc));
    chk("perf_illegal", {32'b0, a_perf_ill}, 64'(a_ill_cnt));
`endif

    // Backpressure: two words fill the buffer, the third is held at the source
    a_out_ready = 1'b0;
    push(1'b0, 32'h00100093, 3'b000, 5'd1, 64'd1, 1'b0);
    push(1'b0, 32'h00200093, 3'b000, 5'd2, 64'd2, 1'b0);
    a_in_valid = 1'b1; a_in_inst = 32'h00300093; a_in_immsrc = 3'b000; a_in_tag = 5'd3;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("full_in_ready", {63'b0, a_in_ready}, 64'd0);
      chk("stall_out_valid", {63'b0, a_out_valid}, 64'd1);
      chk("stall_out_tag", {59'b0, a_out_tag}, 64'd1);
      chk("stall_out_imm", a_out_imm, 64'd1);
    end
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    push(1'b0, 32'h00300093, 3'b000, 5'd3, 64'd3, 1'b0);
    repeat (3) @(posedge clk);
    #1;

    // Streaming: 16 back-to-back words with out_ready held high
    outs0  = a_outs;
    waits0 = push_waits;
    for (int i = 0; i < 16; i++) begin
      push(1'b0, {12'(i + 16), 20'h00093}, 3'b000, 5'(i), 64'(i + 16), 1'b0);
    end
    @(posedge clk);
    #1;
    chk("stream_outputs_consecutive", 64'(a_outs - outs0), 64'd16);
    chk("stream_no_in_ready_stall", 64'(push_waits - waits0), 64'd0);

    // Reset with two entries buffered
    a_out_ready = 1'b0;
    push(1'b0, 32'h00700093, 3'b000, 5'd7, 64'd7, 1'b0);
    push(1'b0, 32'h00800093, 3'b000, 5'd8, 64'd8, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    a_q.delete();
    a_acc = 0;
    a_ill_cnt = 0;
    @(negedge clk);
    chk("mid_rst_out_valid", {63'b0, a_out_valid}, 64'd0);
    chk("mid_rst_in_ready", {63'b0, a_in_ready}, 64'd1);
    chk("mid_rst_out_imm", a_out_imm, 64'd0);
    chk("mid_rst_out_tag", {59'b0, a_out_tag}, 64'd0);
`ifdef IMMGEN_PIPE_PERF_EN
    chk("mid_rst_perf_acc", {32'b0, a_perf_acc}, 64'd0);
    chk("mid_rst_perf_ill", {32'b0, a_perf_ill}, 64'd0);
`endif
    @(posedge clk);
    #1 a_out_ready = 1'b1;
    push(1'b0, 32'h0002D073, 3'b110, 5'd9, 64'd0, 1'b1);

    // Drain
    k = 0;
    while ((a_q.size() != 0 || b_q.size() != 0) && k < 100) begin
      k++;
      @(posedge clk);
    end
    #1;
    chk("drain_a_queue_empty", 64'(a_q.size()), 64'd0);
    chk("drain_b_queue_empty", 64'(b_q.size()), 64'd0);
`ifdef IMMGEN_PIPE_PERF_EN
    chk("post_rst_perf_illegal", {32'b0, a_perf_ill}, 64'(a_ill_cnt));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
